// File: rtl/aes_core_ctrl.sv
// AES round-sequencing controller: host handshake, round-key fetch, core command and result capture.
// Optional block counter enabled by defining AES_CTRL_PERF_CNT_EN.
module aes_core_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pt_0_in,
  input  logic [DATA_WIDTH-1:0] pt_1_in,
  input  logic [DATA_WIDTH-1:0] pt_2_in,
  input  logic [DATA_WIDTH-1:0] pt_3_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ct_0_out,
  output logic [DATA_WIDTH-1:0] ct_1_out,
  output logic [DATA_WIDTH-1:0] ct_2_out,
  output logic [DATA_WIDTH-1:0] ct_3_out,
  output logic                  err_out,
  output logic [31:0]           blk_cnt_out,
  output logic                  rk_rd_en,
  output logic [3:0]            rk_addr,
  input  logic [DATA_WIDTH-1:0] rk_0_in,
  input  logic [DATA_WIDTH-1:0] rk_1_in,
  input  logic [DATA_WIDTH-1:0] rk_2_in,
  input  logic [DATA_WIDTH-1:0] rk_3_in,
  output logic [2:0]            FSM_core_out,
  output logic [3:0]            core_count_out,
  output logic [DATA_WIDTH-1:0] core_text_0_out,
  output logic [DATA_WIDTH-1:0] core_text_1_out,
  output logic [DATA_WIDTH-1:0] core_text_2_out,
  output logic [DATA_WIDTH-1:0] core_text_3_out,
  output logic [DATA_WIDTH-1:0] core_key_0_out,
  output logic [DATA_WIDTH-1:0] core_key_1_out,
  output logic [DATA_WIDTH-1:0] core_key_2_out,
  output logic [DATA_WIDTH-1:0] core_key_3_out,
  input  logic [DATA_WIDTH-1:0] core_text_0_in,
  input  logic [DATA_WIDTH-1:0] core_text_1_in,
  input  logic [DATA_WIDTH-1:0] core_text_2_in,
  input  logic [DATA_WIDTH-1:0] core_text_3_in,
  input  logic                  cipher_dv_flag
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRound, StWaitDv, StOut} state_e;

  state_e                          state_q;
  logic [3:0]                      round_q;
  logic [TmoW-1:0]                 tmo_q;
  logic                            in_ready_q;
  logic                            out_valid_q;
  logic                            err_q;
  logic                            rk_rd_en_q;
  logic [3:0]                      rk_addr_q;
  logic [2:0]                      fsm_q;
  logic                            key_en_q;
  logic [3:0][DATA_WIDTH-1:0]      text_q;
  logic [3:0][DATA_WIDTH-1:0]      ct_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      round_q     <= '0;
      tmo_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rk_rd_en_q  <= 1'b0;
      rk_addr_q   <= '0;
      fsm_q       <= 3'b000;
      key_en_q    <= 1'b0;
      text_q      <= '0;
      ct_q        <= '0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            text_q     <= {pt_3_in, pt_2_in, pt_1_in, pt_0_in};
            in_ready_q <= 1'b0;
            fsm_q      <= 3'b001;
            rk_rd_en_q <= 1'b1;
            rk_addr_q  <= 4'd0;
            round_q    <= 4'd0;
            state_q    <= StLoad;
          end else begin
            in_ready_q <= key_valid_in;
          end
        end
        StLoad: begin
          fsm_q     <= 3'b010;
          key_en_q  <= 1'b1;
          rk_addr_q <= 4'd1;
          state_q   <= StRound;
        end
        StRound: begin
          if (round_q == 4'd10) begin
            fsm_q    <= 3'b011;
            key_en_q <= 1'b0;
            tmo_q    <= '0;
            state_q  <= StWaitDv;
          end else begin
            round_q <= round_q + 4'd1;
            // The last round needs no further key fetch
            rk_rd_en_q <= (round_q != 4'd9);
            rk_addr_q  <= (round_q != 4'd9) ? round_q + 4'd2 : 4'd10;
          end
        end
        StWaitDv: begin
          if (cipher_dv_flag) begin
            ct_q        <= {core_text_3_in, core_text_2_in, core_text_1_in, core_text_0_in};
            out_valid_q <= 1'b1;
            fsm_q       <= 3'b000;
            round_q     <= '0;
            rk_addr_q   <= '0;
            state_q     <= StOut;
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            fsm_q      <= 3'b000;
            round_q    <= '0;
            rk_addr_q  <= '0;
            in_ready_q <= key_valid_in;
            state_q    <= StIdle;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= key_valid_in;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef AES_CTRL_PERF_CNT_EN
  logic [31:0] blk_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q <= '0;
    end else if (state_q == StOut && out_ready) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign blk_cnt_out = blk_cnt_q;
`else
  assign blk_cnt_out = '0;
`endif

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign err_out         = err_q;
  assign rk_rd_en        = rk_rd_en_q;
  assign rk_addr         = rk_addr_q;
  assign FSM_core_out    = fsm_q;
  assign core_count_out  = round_q;
  assign core_text_0_out = text_q[0];
  assign core_text_1_out = text_q[1];
  assign core_text_2_out = text_q[2];
  assign core_text_3_out = text_q[3];
  assign ct_0_out        = ct_q[0];
  assign ct_1_out        = ct_q[1];
  assign ct_2_out        = ct_q[2];
  assign ct_3_out        = ct_q[3];

  // The key store answers one cycle after the read, so its data is forwarded during ROUND
  // under a registered enable rather than re-registered (which would skew keys by a round).
  assign core_key_0_out = key_en_q ? rk_0_in : '0;
  assign core_key_1_out = key_en_q ? rk_1_in : '0;
  assign core_key_2_out = key_en_q ? rk_2_in : '0;
  assign core_key_3_out = key_en_q ? rk_3_in : '0;

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Self-checking bench for aes_core_ctrl: random blocks against a cycle-timeline reference model.
module tb_aes_core_ctrl;

  logic              clk;
  logic              rst;
  logic              key_valid_in;
  logic              in_valid;
  logic              in_ready;
  logic [3:0][31:0]  pt_i;
  logic              out_valid;
  logic              out_ready;
  logic [3:0][31:0]  ct_o;
  logic              err_out;
  logic [31:0]       blk_cnt_out;
  logic              rk_rd_en;
  logic [3:0]        rk_addr;
  logic [3:0][31:0]  rk_i;
  logic [2:0]        fsm_o;
  logic [3:0]        count_o;
  logic [3:0][31:0]  ctext_o;
  logic [3:0][31:0]  ckey_o;
  logic [3:0][31:0]  ctin_i;
  logic              cipher_dv_flag;

  logic [31:0]       sched [44];
  logic [3:0][31:0]  last_ct;
  int                blk_model;
  int                checks;
  int                errors;

  aes_core_ctrl #(
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid_in   (key_valid_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .pt_0_in        (pt_i[0]),
    .pt_1_in        (pt_i[1]),
    .pt_2_in        (pt_i[2]),
    .pt_3_in        (pt_i[3]),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ct_0_out       (ct_o[0]),
    .ct_1_out       (ct_o[1]),
    .ct_2_out       (ct_o[2]),
    .ct_3_out       (ct_o[3]),
    .err_out        (err_out),
    .blk_cnt_out    (blk_cnt_out),
    .rk_rd_en       (rk_rd_en),
    .rk_addr        (rk_addr),
    .rk_0_in        (rk_i[0]),
    .rk_1_in        (rk_i[1]),
    .rk_2_in        (rk_i[2]),
    .rk_3_in        (rk_i[3]),
    .FSM_core_out   (fsm_o),
    .core_count_out (count_o),
    .core_text_0_out(ctext_o[0]),
    .core_text_1_out(ctext_o[1]),
    .core_text_2_out(ctext_o[2]),
    .core_text_3_out(ctext_o[3]),
    .core_key_0_out (ckey_o[0]),
    .core_key_1_out (ckey_o[1]),
    .core_key_2_out (ckey_o[2]),
    .core_key_3_out (ckey_o[3]),
    .core_text_0_in (ctin_i[0]),
    .core_text_1_in (ctin_i[1]),
    .core_text_2_in (ctin_i[2]),
    .core_text_3_in (ctin_i[3]),
    .cipher_dv_flag (cipher_dv_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Round-key store: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (rk_rd_en && rk_addr <= 4'd10) begin
      for (int x = 0; x < 4; x++) rk_i[x] <= sched[4 * rk_addr + x];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][31:0] rnd128();
    logic [3:0][31:0] v;
    for (int x = 0; x < 4; x++) v[x] = $urandom;
    return v;
  endfunction

  function automatic logic [3:0][31:0] key_of(input int r);
    logic [3:0][31:0] v;
    for (int x = 0; x < 4; x++) v[x] = sched[4 * r + x];
    return v;
  endfunction

  function automatic logic [31:0] blk_expected();
`ifdef AES_CTRL_PERF_CNT_EN
    return 32'(blk_model);
`else
    return 32'd0;
`endif
  endfunction

  // d >= 0: dv arrives d cycles after the first finish-command cycle; d < 0: core never answers.
  task automatic run_block(input logic [3:0][31:0] pt, input logic [3:0][31:0] ct, input int d,
                           input int bp);
    int n;
    out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      return;
    end
    pt_i = pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'(($urandom_range(0, 1)));
    key_valid_in = 1'(($urandom_range(0, 1)));
    pt_i = rnd128();
    checks++;
    if (fsm_o !== 3'b001 || count_o !== 4'd0 || ctext_o !== pt || rk_rd_en !== 1'b1 ||
        rk_addr !== 4'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load: fsm=%b cnt=%0d text=%h rd=%b addr=%0d rdy=%b required 001 0 %h 1 0 0",
               fsm_o, count_o, ctext_o, rk_rd_en, rk_addr, in_ready, pt);
    end
    for (int i = 0; i <= 10; i++) begin
      cipher_dv_flag = 1'(($urandom_range(0, 1)));
      ctin_i = rnd128();
      step();
      checks++;
      if (fsm_o !== 3'b010 || count_o !== 4'(i) || ckey_o !== key_of(i) ||
          rk_rd_en !== (i < 10) || (i < 10 && rk_addr !== 4'(i + 1)) || in_ready !== 1'b0 ||
          out_valid !== 1'b0) begin
        errors++;
        $display("FAIL round%0d: fsm=%b cnt=%0d key=%h rd=%b addr=%0d required 010 %0d %h %b %0d",
                 i, fsm_o, count_o, ckey_o, rk_rd_en, rk_addr, i, key_of(i), (i < 10), i + 1);
      end
    end
    cipher_dv_flag = 1'b0;
    key_valid_in = 1'b1;
    step();
    checks++;
    if (fsm_o !== 3'b011 || out_valid !== 1'b0 || err_out !== 1'b0) begin
      errors++;
      $display("FAIL finish_cmd: fsm=%b ov=%b err=%b required 011 0 0", fsm_o, out_valid, err_out);
    end
    if (d >= 0) begin
      for (int k = 0; k <= d; k++) begin
        cipher_dv_flag = (k == d);
        ctin_i = (k == d) ? ct : rnd128();
        step();
        if (k < d) begin
          checks++;
          if (fsm_o !== 3'b011 || out_valid !== 1'b0 || err_out !== 1'b0) begin
            errors++;
            $display("FAIL wait_dv%0d: fsm=%b ov=%b err=%b required 011 0 0", k, fsm_o,
                     out_valid, err_out);
          end
        end
      end
      cipher_dv_flag = 1'b0;
      ctin_i = rnd128();
      last_ct = ct;
      checks++;
      if (out_valid !== 1'b1 || ct_o !== ct || err_out !== 1'b0) begin
        errors++;
        $display("FAIL out_latency(d=%0d): ov=%b ct=%h err=%b required 1 %h 0", d, out_valid,
                 ct_o, err_out, ct);
      end
      for (int b = 0; b < bp; b++) begin
        in_valid = 1'(($urandom_range(0, 1)));
        cipher_dv_flag = 1'(($urandom_range(0, 1)));
        ctin_i = rnd128();
        step();
        checks++;
        if (out_valid !== 1'b1 || ct_o !== ct || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure%0d: ov=%b ct=%h rdy=%b required 1 %h 0", b, out_valid,
                   ct_o, in_ready, ct);
        end
      end
      in_valid = 1'b0;
      cipher_dv_flag = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      blk_model++;
      checks++;
      if (out_valid !== 1'b0 || fsm_o !== 3'b000 || in_ready !== 1'b1 ||
          blk_cnt_out !== blk_expected()) begin
        errors++;
        $display("FAIL out_done: ov=%b fsm=%b rdy=%b blk=%0d required 0 000 1 %0d", out_valid,
                 fsm_o, in_ready, blk_cnt_out, blk_expected());
      end
    end else begin
      for (int j = 1; j <= 16; j++) begin
        step();
        checks++;
        if (j < 16) begin
          if (fsm_o !== 3'b011 || err_out !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait%0d: fsm=%b err=%b required 011 0", j, fsm_o, err_out);
          end
        end else if (err_out !== 1'b1 || out_valid !== 1'b0 || ct_o !== last_ct) begin
          errors++;
          $display("FAIL tmo_pulse: err=%b ov=%b ct=%h required 1 0 %h", err_out, out_valid,
                   ct_o, last_ct);
        end
      end
      step();
      checks++;
      if (err_out !== 1'b0 || in_ready !== 1'b1 || fsm_o !== 3'b000 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL tmo_after: err=%b rdy=%b fsm=%b ov=%b required 0 1 000 0", err_out,
                 in_ready, fsm_o, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_valid_in = 1'b0;
    step();
    step();
    blk_model = 0;
    last_ct = '0;
    checks++;
    if ({in_ready, out_valid, err_out, rk_rd_en, rk_addr, fsm_o, count_o} !== '0 ||
        ct_o !== '0 || ctext_o !== '0 || ckey_o !== '0 || blk_cnt_out !== '0) begin
      errors++;
      $display("FAIL reset: rdy=%b ov=%b err=%b rd=%b addr=%0d fsm=%b cnt=%0d ct=%h blk=%0d required 0",
               in_ready, out_valid, err_out, rk_rd_en, rk_addr, fsm_o, count_o, ct_o, blk_cnt_out);
    end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_key: in_ready=%b required 0", in_ready);
    end
    key_valid_in = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_key: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_nominal();
    logic [3:0][31:0] pt;
    logic [3:0][31:0] ct;
    pt = {32'h72797074, 32'h20456E63, 32'h6E636564, 32'h41647661};
    ct = {32'hf87c4904, 32'he9eada49, 32'h39560b0f, 32'h6f5ddb7f};
    run_block(pt, ct, 2, 0);
  endtask

  task automatic test_back_to_back();
    run_block(rnd128(), rnd128(), 1, 10);
    run_block(rnd128(), rnd128(), 0, 0);
  endtask

  task automatic test_random();
    run_block(rnd128(), rnd128(), 15, 1);
    for (int n = 0; n < 6; n++) begin
      run_block(rnd128(), rnd128(), $urandom_range(0, 15), $urandom_range(0, 4));
    end
  endtask

  task automatic test_timeout();
    run_block(rnd128(), rnd128(), -1, 0);
    run_block(rnd128(), rnd128(), 3, 0);
  endtask

  task automatic test_reset_mid_block();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    pt_i = rnd128();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (count_o !== 4'd5) begin
      errors++;
      $display("FAIL mid_count: core_count=%0d required 5", count_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    key_valid_in = 1'b0;
    blk_model = 0;
    last_ct = '0;
    checks++;
    if (fsm_o !== 3'b000 || out_valid !== 1'b0 || err_out !== 1'b0 || count_o !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: fsm=%b ov=%b err=%b cnt=%0d required 000 0 0 0", fsm_o, out_valid,
               err_out, count_o);
    end
    for (int i = 0; i < 30; i++) begin
      cipher_dv_flag = 1'(($urandom_range(0, 1)));
      ctin_i = rnd128();
      step();
      checks++;
      if (out_valid !== 1'b0 || err_out !== 1'b0 || fsm_o !== 3'b000) begin
        errors++;
        $display("FAIL mid_discard%0d: ov=%b err=%b fsm=%b required 0 0 000", i, out_valid,
                 err_out, fsm_o);
      end
    end
    cipher_dv_flag = 1'b0;
    key_valid_in = 1'b1;
  endtask

  task automatic test_perf_cnt();
    for (int n = 0; n < 3; n++) run_block(rnd128(), rnd128(), $urandom_range(0, 5), 0);
    checks++;
`ifdef AES_CTRL_PERF_CNT_EN
    if (blk_cnt_out !== 32'd3) begin
      errors++;
      $display("FAIL perf_cnt: blk_cnt=%0d required 3", blk_cnt_out);
    end
`else
    if (blk_cnt_out !== 32'd0) begin
      errors++;
      $display("FAIL perf_cnt: blk_cnt=%0d required 0", blk_cnt_out);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    blk_model = 0;
    last_ct = '0;
    rst = 1'b1;
    key_valid_in = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cipher_dv_flag = 1'b0;
    pt_i = '0;
    ctin_i = '0;
    rk_i = '0;
    for (int i = 0; i < 44; i++) sched[i] = $urandom;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_mid_block();
    test_perf_cnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
